// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data access. Data is served first, and the pipeline stalls until both accesses finish.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    state_t      state;
    logic        d_done;
    logic        i_done;
    logic        need_d;
    logic        need_i;
    logic [31:0] stall_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Done flags remember which accesses of the current step have finished.
    assign need_d      = (dm_read_i | dm_write_i) & ~d_done;
    assign need_i      = if_req_i & ~i_done;
    assign stall_o     = need_d | need_i | (state != IDLE);
    assign stall_cnt_o = stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            d_done      <= 1'b0;
            i_done      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            stall_cnt   <= 32'd0;
        end else begin
            if (stall_o) begin
                stall_cnt <= sat_inc(stall_cnt);
            end else begin
                d_done <= 1'b0;
                i_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (need_d) begin
                        state       <= BUSY_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_write_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (need_i) begin
                        state      <= BUSY_I;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
                end
                BUSY_D: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        d_done    <= 1'b1;
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        i_done    <= 1'b1;
                        if_data_o <= mem_rdata_i;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a variable-latency memory model pops expected accesses
// from a scoreboard queue as requests appear, and each pipeline step is checked.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        dm_read_i = 1'b0;
    logic        dm_write_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic [31:0] stall_cnt_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        cur;
    logic [31:0] mem [logic [31:0]];
    int          lat = 1;
    int          acc_cyc = 0;
    int          req_cycles = 0;
    logic        spur = 1'b0;
    longint      exp_stall = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: ack arrives in the lat-th request cycle.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (acc_cyc == 0) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_req", mem_addr_o, 32'hFFFF_FFFF);
                    cur = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o};
                end else begin
                    cur = exp_q.pop_front();
                    check_val("req_we", {31'd0, mem_we_o}, {31'd0, cur.we});
                    if (cur.we) check_val("req_wdata", mem_wdata_o, cur.wdata);
                end
            end
            check_val("req_addr", mem_addr_o, cur.addr);
            acc_cyc++;
            req_cycles++;
            if (acc_cyc == lat) begin
                mem_ack_i = 1'b1;
                if (cur.we) begin
                    mem[cur.addr] = cur.wdata;
                    mem_rdata_i = 32'h0BAD_0BAD;
                end else begin
                    mem_rdata_i = mem_rd(cur.addr);
                end
            end else begin
                mem_ack_i = 1'b0;
            end
        end else begin
            acc_cyc = 0;
            mem_ack_i = spur;
            mem_rdata_i = spur ? 32'hBAD0_BAD0 : 32'h0;
        end
    end

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] wd);
        acc_t e;
        e.we = we;
        e.addr = a;
        e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that advances the pipeline.
    task automatic run_step(input string tag, input logic ireq, input logic [31:0] iaddr,
                            input logic rd, input logic wr, input logic [31:0] daddr,
                            input logic [31:0] wd, input int lat_v, input int exp_cyc,
                            input int chg_at);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        lat = lat_v;
        req_cycles = 0;
        if_req_i = ireq;
        if_addr_i = iaddr;
        dm_read_i = rd;
        dm_write_i = wr;
        dm_addr_i = daddr;
        dm_wdata_i = wd;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!stall_o) done = 1'b1;
            else begin
                n++;
                if (n == chg_at) dm_addr_i = 32'h200;
            end
        end
        if (!done) check_val({tag, "_timeout"}, 32'd1, 32'd0);
        check_val({tag, "_stall_cycles"}, n, exp_cyc);
        exp_stall = exp_stall + exp_cyc;
        if (exp_stall > 64'hFFFF_FFFF) exp_stall = 64'hFFFF_FFFF;
        check_val({tag, "_stall_cnt"}, stall_cnt_o, exp_stall[31:0]);
        @(posedge clk);
        #1;
        if_req_i = 1'b0;
        dm_read_i = 1'b0;
        dm_write_i = 1'b0;
    endtask

    initial begin
        mem[32'h40]  = 32'h2008_0005;
        mem[32'h44]  = 32'h8C09_0100;
        mem[32'h100] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_val("rst_req", {31'd0, mem_req_o}, 32'd0);
        check_val("rst_we", {31'd0, mem_we_o}, 32'd0);
        check_val("rst_addr", mem_addr_o, 32'd0);
        check_val("rst_wdata", mem_wdata_o, 32'd0);
        check_val("rst_if_data", if_data_o, 32'd0);
        check_val("rst_dm_rdata", dm_rdata_o, 32'd0);
        check_val("rst_stall_cnt", stall_cnt_o, 32'd0);
        check_val("rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;

        // Fetch only, latency 3
        push(1'b0, 32'h40, 32'h0);
        run_step("fetch", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3, 4, 0);
        check_val("fetch_req_cycles", req_cycles, 32'd3);
        check_val("fetch_if_data", if_data_o, 32'h2008_0005);

        // Load plus fetch: data first
        push(1'b0, 32'h100, 32'h0);
        push(1'b0, 32'h44, 32'h0);
        run_step("lw_fetch", 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 2, 6, 0);
        check_val("lw_fetch_req_cycles", req_cycles, 32'd4);
        check_val("lw_fetch_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check_val("lw_fetch_if_data", if_data_o, 32'h8C09_0100);

        // Store, no fetch
        push(1'b1, 32'h8, 32'hDEAD_BEEF);
        run_step("sw", 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1, 2, 0);
        check_val("sw_dm_rdata_kept", dm_rdata_o, 32'h1234_5678);
        check_val("sw_mem_written", mem_rd(32'h8), 32'hDEAD_BEEF);
        check_val("sw_if_data_kept", if_data_o, 32'h8C09_0100);

        // Address input changes while the load is in flight
        mem[32'h100] = 32'hCAFE_0001;
        push(1'b0, 32'h100, 32'h0);
        run_step("addr_chg", 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4, 5, 2);
        check_val("addr_chg_dm_rdata", dm_rdata_o, 32'hCAFE_0001);

        // Spurious ack while idle
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(negedge clk);
        check_val("spur_req", {31'd0, mem_req_o}, 32'd0);
        check_val("spur_stall", {31'd0, stall_o}, 32'd0);
        check_val("spur_dm_rdata", dm_rdata_o, 32'hCAFE_0001);
        check_val("spur_if_data", if_data_o, 32'h8C09_0100);
        check_val("spur_stall_cnt", stall_cnt_o, exp_stall[31:0]);
        @(posedge clk);
        #1;

        // Read and write together count as a write
        push(1'b1, 32'hC, 32'h0000_0055);
        run_step("rdwr", 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 32'h0000_0055, 1, 2, 0);
        check_val("rdwr_dm_rdata_kept", dm_rdata_o, 32'hCAFE_0001);
        check_val("rdwr_mem_written", mem_rd(32'hC), 32'h0000_0055);

        // Reset in the second busy cycle of a fetch
        push(1'b0, 32'h44, 32'h0);
        lat = 5;
        if_req_i = 1'b1;
        if_addr_i = 32'h44;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        if_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_val("midrst_req", {31'd0, mem_req_o}, 32'd0);
        check_val("midrst_stall", {31'd0, stall_o}, 32'd0);
        check_val("midrst_addr", mem_addr_o, 32'd0);
        check_val("midrst_if_data", if_data_o, 32'd0);
        check_val("midrst_dm_rdata", dm_rdata_o, 32'd0);
        check_val("midrst_stall_cnt", stall_cnt_o, 32'd0);
        exp_stall = 0;

        // Saturation of the stall counter
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        exp_stall = 64'hFFFF_FFFD;
        @(posedge clk);
        #1;
        push(1'b0, 32'h40, 32'h0);
        run_step("sat", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3, 4, 0);
        check_val("sat_if_data", if_data_o, 32'h2008_0005);

        check_val("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
